// File: rtl/conditional_sum_adder.sv
// Registered WIDTH-bit conditional-sum adder: every bit precomputes its sum and carry
// for both carry-in assumptions, and a log2(WIDTH)-level mux tree merges the blocks.
module conditional_sum_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] S,
  output logic             cOut
);

  // WIDTH must be a power of two and at least 2; the merge tree assumes exact halving.
  localparam int LEVELS = $clog2(WIDTH);

  genvar k, j;

  // Level k holds WIDTH/2^k blocks of 2^k bits. Each block carries a conditional sum and
  // carry for carry-in 0 (ss0/cc0) and carry-in 1 (ss1/cc1).
  generate
    for (k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int BLK = 1 << k;
      localparam int NB  = WIDTH / BLK;

      logic [WIDTH-1:0] ss0;
      logic [WIDTH-1:0] ss1;
      logic [NB-1:0]    cc0;
      logic [NB-1:0]    cc1;

      if (k == 0) begin : g_leaf
        assign ss0 = x ^ y;
        assign ss1 = ~(x ^ y);
        assign cc0 = x & y;
        assign cc1 = x | y;
      end else begin : g_merge
        localparam int HALF = BLK / 2;

        for (j = 0; j < NB; j++) begin : g_blk
          logic lo_c0;
          logic lo_c1;

          assign lo_c0 = g_lvl[k-1].cc0[2*j];
          assign lo_c1 = g_lvl[k-1].cc1[2*j];

          // Lower half passes through unchanged.
          assign ss0[j*BLK +: HALF] = g_lvl[k-1].ss0[j*BLK +: HALF];
          assign ss1[j*BLK +: HALF] = g_lvl[k-1].ss1[j*BLK +: HALF];

          // Upper half is picked by the lower half's carry under the same assumption.
          assign ss0[j*BLK+HALF +: HALF] = lo_c0 ? g_lvl[k-1].ss1[j*BLK+HALF +: HALF]
                                                 : g_lvl[k-1].ss0[j*BLK+HALF +: HALF];
          assign ss1[j*BLK+HALF +: HALF] = lo_c1 ? g_lvl[k-1].ss1[j*BLK+HALF +: HALF]
                                                 : g_lvl[k-1].ss0[j*BLK+HALF +: HALF];

          assign cc0[j] = lo_c0 ? g_lvl[k-1].cc1[2*j+1] : g_lvl[k-1].cc0[2*j+1];
          assign cc1[j] = lo_c1 ? g_lvl[k-1].cc1[2*j+1] : g_lvl[k-1].cc0[2*j+1];
        end
      end
    end
  endgenerate

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  // Final stage: the real carry-in chooses between the two full-width results.
  assign sum_next   = c0 ? g_lvl[LEVELS].ss1    : g_lvl[LEVELS].ss0;
  assign carry_next = c0 ? g_lvl[LEVELS].cc1[0] : g_lvl[LEVELS].cc0[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S    <= '0;
      cOut <= 1'b0;
    end else begin
      S    <= sum_next;
      cOut <= carry_next;
    end
  end

endmodule

// File: tb/tb_conditional_sum_adder.sv
// Bench for conditional_sum_adder: directed cases, pipelined streams, sweeps and random
// operands checked against plain integer addition.
module tb_conditional_sum_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         c0;
  logic [W-1:0] S;
  logic         cOut;

  int n_tests;
  int n_fail;
  logic [W:0] exp_q[$];

  conditional_sum_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .y    (y),
    .c0   (c0),
    .S    (S),
    .cOut (cOut)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    int unsigned total;
    total = int'(a) + int'(b) + int'(c);
    return total[W:0];
  endfunction

  // Driver: new operands on the falling edge, expectation queued for the next rising edge.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    x  = a;
    y  = b;
    c0 = c;
    exp_q.push_back(model(a, b, c));
  endtask

  task automatic test_reset();
    logic [W:0] exp;
    rst_n = 1'b0;
    x = 8'hFF; y = 8'hFF; c0 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({cOut, S} !== 9'h000) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got cOut=%b S=%h, want 0/00", i, cOut, S);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp = model(8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL reset_release: got cOut=%b S=%h, want %b/%h", cOut, S, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] xa[6] = '{8'd12, 8'd12, 8'd255, 8'd255, 8'b11110000, 8'd1};
    logic [W-1:0] ya[6] = '{8'd5,  8'd5,  8'd1,   8'd1,   8'b00001111, 8'd1};
    logic         ca[6] = '{1'b0,  1'b1,  1'b0,   1'b1,   1'b1,        1'b0};
    logic [W:0]   want[6] = '{9'd17, 9'd18, 9'h100, 9'h101, 9'h100, 9'd2};
    logic [W:0]   got;
    for (int i = 0; i < 6; i++) begin
      drive(xa[i], ya[i], ca[i]);
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      n_tests++;
      if ({cOut, S} !== want[i]) begin
        n_fail++;
        $display("FAIL directed[%0d] %0d+%0d+%0d: got %h, want %h",
                 i, xa[i], ya[i], ca[i], {cOut, S}, want[i]);
      end
      // Inputs moving between edges must not disturb the held result.
      got = {cOut, S};
      x = ~x; y = y + 8'd3; c0 = ~c0;
      #2;
      n_tests++;
      if ({cOut, S} !== got) begin
        n_fail++;
        $display("FAIL hold_between_edges[%0d]: got %h, want %h", i, {cOut, S}, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp;
    exp_q.delete();
    drive(8'd12, 8'd5, 1'b0);
    @(posedge clk); #1;
    drive(8'd255, 8'd1, 1'b0);
    exp = exp_q.pop_front();
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL back_to_back[0]: got %h, want %h", {cOut, S}, exp);
    end
    @(posedge clk); #1;
    drive(8'd1, 8'd1, 1'b0);
    exp = exp_q.pop_front();
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL back_to_back[1]: got %h, want %h", {cOut, S}, exp);
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL back_to_back[2]: got %h, want %h", {cOut, S}, exp);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] ys[8] = '{8'h00, 8'h01, 8'h55, 8'hAA, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    logic [W:0] exp;
    int errs;
    errs = 0;
    for (int yi = 0; yi < 8; yi++) begin
      for (int xv = 0; xv < 256; xv++) begin
        for (int c = 0; c < 2; c++) begin
          drive(xv[W-1:0], ys[yi], c[0]);
          @(posedge clk); #1;
          exp = exp_q.pop_front();
          n_tests++;
          if ({cOut, S} !== exp) begin
            n_fail++;
            errs++;
            if (errs <= 10)
              $display("FAIL sweep %0d+%0d+%0d: got %h, want %h", xv, ys[yi], c, {cOut, S}, exp);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic c;
    logic [W:0] exp;
    int errs;
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      c = 1'($urandom_range(0, 1));
      drive(a, b, c);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      n_tests++;
      if ({cOut, S} !== exp) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random %0d+%0d+%0d: got %h, want %h", a, b, c, {cOut, S}, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W:0] exp;
    drive(8'hC3, 8'h5A, 1'b1);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got %h, want %h", {cOut, S}, exp);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cOut, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_clear: got %h, want 000", {cOut, S});
    end
    drive(8'h80, 8'h80, 1'b0);
    #1 rst_n = 1'b1;
    n_tests++;
    if ({cOut, S} !== 9'h000) begin
      n_fail++;
      $display("FAIL mid_reset_after_release: got %h, want 000", {cOut, S});
    end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    n_tests++;
    if ({cOut, S} !== exp) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %h, want %h", {cOut, S}, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_sweep();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
